adc_channel_scanner: RTL

Parametrised sequencer that sits between game logic (joystick/paddle inputs) and the modular ADC sample interface of the SoC. It issues single-beat conversion commands over a configurable channel list and averages 2^AVG_LOG2 responses per channel. It holds the latest averaged result for each channel in output registers, in both single-shot and continuous scan modes. A response timeout keeps a missing conversion from stalling a scan.

---
 rtl/adc_channel_scanner_if.sv | 30 +++
 rtl/adc_channel_scanner.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/adc_channel_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_channel_scanner_if
//  Description : Command/response bus between the channel scanner and the
//                modular ADC sample interface (single-beat packets).
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_channel_scanner_if;
  logic       cmd_valid;
  logic [4:0] cmd_channel;
  logic       cmd_sop;
  logic       cmd_eop;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [4:0] rsp_channel;
  logic [11:0] rsp_data;

  // Scanner side: issues commands, consumes responses
  modport master (
    output cmd_valid, cmd_channel, cmd_sop, cmd_eop,
    input  cmd_ready, rsp_valid, rsp_channel, rsp_data
  );

  // ADC side: accepts commands, produces responses
  modport slave (
    input  cmd_valid, cmd_channel, cmd_sop, cmd_eop,
    output cmd_ready, rsp_valid, rsp_channel, rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/adc_channel_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : adc_channel_scanner
//  Description : Scans a fixed channel list on the ADC, averages 2^AVG_LOG2
//                conversions per channel and holds the latest average of
//                each channel. Single-shot or continuous; a per-command
//                response timeout keeps a lost conversion from stalling.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_channel_scanner #(
  parameter int                  NUM_CH      = 2,
  parameter logic [5*NUM_CH-1:0] CH_LIST     = {5'd2, 5'd1},
  parameter int                  AVG_LOG2    = 2,
  parameter int                  TIMEOUT_CYC = 1023
) (
  input  wire                   clk_clk,
  input  wire                   reset_reset,
  input  wire                   start,
  input  wire                   continuous,
  adc_channel_scanner_if.master bus,
  output logic [12*NUM_CH-1:0]  result,
  output logic [NUM_CH-1:0]     result_valid,
  output logic                  scan_done,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int c_idx_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_cnt_w = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int c_acc_w = 12 + AVG_LOG2;
  localparam int c_tmo_w = $clog2(TIMEOUT_CYC);

  localparam logic [c_idx_w-1:0] c_last_ch  = c_idx_w'(NUM_CH - 1);
  localparam logic [c_cnt_w-1:0] c_last_smp = c_cnt_w'((1 << AVG_LOG2) - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_idx_w-1:0]    r_ch_idx;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_acc_w-1:0]    r_acc;
  logic [c_tmo_w-1:0]    r_tmo;
  logic                  r_cmd_valid;
  logic [4:0]            r_cmd_channel;
  logic [12*NUM_CH-1:0]  r_result;
  logic [NUM_CH-1:0]     r_result_valid;
  logic                  r_scan_done;
  logic                  r_timeout_err;

  logic [4:0]            w_ch_tab [NUM_CH];
  logic [4:0]            w_cur_ch;
  logic [4:0]            w_nxt_ch;
  logic [c_idx_w-1:0]    w_nxt_idx;
  logic                  w_last_ch;
  logic                  w_accept;
  logic                  w_last_smp;
  logic                  w_tmo;
  logic [c_acc_w-1:0]    w_sum;

  // Unpack the channel list into a lookup table indexed by scan position
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_tab
    assign w_ch_tab[g] = CH_LIST[5*g +: 5];
  end

  assign w_last_ch  = (r_ch_idx == c_last_ch);
  assign w_nxt_idx  = w_last_ch ? '0 : r_ch_idx + 1'b1;
  assign w_cur_ch   = w_ch_tab[r_ch_idx];
  assign w_nxt_ch   = w_ch_tab[w_nxt_idx];
  // Responses for other channels (stale or foreign) are simply not accepted
  assign w_accept   = bus.rsp_valid && (bus.rsp_channel == w_cur_ch);
  assign w_last_smp = (r_cnt == c_last_smp);
  assign w_tmo      = (r_tmo == c_tmo_last);
  assign w_sum      = r_acc + c_acc_w'(bus.rsp_data);

  // Scan sequencer: command issue, averaging, timeout and result capture
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state        <= S_IDLE;
      r_ch_idx       <= '0;
      r_cnt          <= '0;
      r_acc          <= '0;
      r_tmo          <= '0;
      r_cmd_valid    <= 1'b0;
      r_cmd_channel  <= 5'd0;
      r_result       <= '0;
      r_result_valid <= '0;
      r_scan_done    <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_scan_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start || continuous) begin
            r_ch_idx      <= '0;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_timeout_err <= 1'b0;
            r_cmd_valid   <= 1'b1;
            r_cmd_channel <= w_ch_tab[0];
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_tmo       <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_accept && !w_last_smp) begin
            r_acc         <= w_sum;
            r_cnt         <= r_cnt + 1'b1;
            r_cmd_valid   <= 1'b1;
            r_cmd_channel <= w_cur_ch;
            r_state       <= S_ISSUE;
          end else if (w_accept || w_tmo) begin
            // Channel finished, either with a full average or abandoned
            if (w_accept) begin
              r_result[12*int'(r_ch_idx) +: 12] <= w_sum[AVG_LOG2 +: 12];
              r_result_valid[r_ch_idx]         <= 1'b1;
            end else begin
              r_timeout_err <= 1'b1;
            end
            r_acc    <= '0;
            r_cnt    <= '0;
            r_ch_idx <= w_nxt_idx;
            if (w_last_ch) begin
              r_scan_done <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_cmd_valid   <= 1'b1;
              r_cmd_channel <= w_nxt_ch;
              r_state       <= S_ISSUE;
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_DONE: begin
          // Continuous rescan bypasses IDLE so the timeout flag survives
          if (continuous) begin
            r_ch_idx      <= '0;
            r_cmd_valid   <= 1'b1;
            r_cmd_channel <= w_ch_tab[0];
            r_state       <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_valid   = r_cmd_valid;
  assign bus.cmd_channel = r_cmd_channel;
  assign bus.cmd_sop     = r_cmd_valid;
  assign bus.cmd_eop     = r_cmd_valid;
  assign result          = r_result;
  assign result_valid    = r_result_valid;
  assign scan_done       = r_scan_done;
  assign timeout_err     = r_timeout_err;
  assign busy            = (r_state != S_IDLE);

endmodule
`default_nettype wire
